// File: rtl/ram_arb_pkg.sv
// Shared definitions for the 256x8 data RAM arbiter: FSM encoding, requester
// indices, default widths and a small one-hot helper.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 8;
    localparam int RAM_DATA_W = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_e;

    function automatic logic [1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way priority picker: one-hot winner from req. Round-robin on ties when
// RAM_ARB_RR_EN is defined, otherwise fixed priority with the CPU first.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

`ifdef RAM_ARB_RR_EN
    // ptr names the requester favoured on a tie (the one not granted last).
    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = owner_onehot(ptr);
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        win = 2'b00;
        if (req[REQ_CPU]) begin
            win = owner_onehot(REQ_CPU);
        end else if (req[REQ_LDR]) begin
            win = owner_onehot(REQ_LDR);
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer sharing the single-port data RAM between the CPU and the
// loader; fully registered outputs. Tie policy selected by RAM_ARB_RR_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    // Handshake: a requester holds req/we/addr/wdata stable until it sees its
    // gnt pulse; gnt is the accept. done pulses one cycle later, carrying rdata.
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_n_cs,
    output logic              ram_n_oe,
    output logic              ram_n_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE     = ST_IDLE;
    localparam logic [1:0] ACCESS   = ST_ACCESS;
    localparam logic [1:0] COMPLETE = ST_COMPLETE;

    logic [1:0]        state;
    logic              owner;
    logic              we_q;
    logic              ptr;
    logic [1:0]        win;
    logic              win_idx;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    ram_arb_pick u_pick (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    assign win_idx   = win[REQ_LDR];
    assign win_we    = win_idx ? we[REQ_LDR] : we[REQ_CPU];
    assign win_addr  = win_idx ? addr1 : addr0;
    assign win_wdata = win_idx ? wdata1 : wdata0;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= REQ_CPU;
            we_q      <= 1'b0;
            ptr       <= REQ_CPU;
            gnt       <= 2'b00;
            done      <= 2'b00;
            rdata     <= '0;
            ram_n_cs  <= 1'b1;
            ram_n_oe  <= 1'b1;
            ram_n_we  <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            gnt  <= 2'b00;
            done <= 2'b00;
            case (state)
                IDLE, COMPLETE: begin
                    if (|req) begin
                        state     <= ACCESS;
                        owner     <= win_idx;
                        we_q      <= win_we;
                        ptr       <= ~win_idx;
                        gnt       <= win;
                        ram_addr  <= win_addr;
                        ram_wdata <= win_wdata;
                        ram_n_cs  <= 1'b0;
                        ram_n_oe  <= win_we;
                        ram_n_we  <= ~win_we;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    // The RAM write (if any) lands on this same edge.
                    state    <= COMPLETE;
                    done     <= owner_onehot(owner);
                    ram_n_cs <= 1'b1;
                    ram_n_oe <= 1'b1;
                    ram_n_we <= 1'b1;
                    if (!we_q) begin
                        rdata <= ram_rdata;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter; build with RAM_ARB_RR_EN to
// check the round-robin variant.
module tb_ram_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int EXP_W = 2 + AW + DW;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          req0_r = 1'b0, req1_r = 1'b0, we0_r = 1'b0, we1_r = 1'b0;
    logic [1:0]    req, we, gnt, done, dbg_state;
    logic [AW-1:0] addr0 = '0, addr1 = '0, ram_addr;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, rdata, ram_wdata, ram_rdata;
    logic          ram_n_cs, ram_n_oe, ram_n_we;

    assign req = {req1_r, req0_r};
    assign we  = {we1_r, we0_r};

    ram_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .done(done), .rdata(rdata),
        .ram_n_cs(ram_n_cs), .ram_n_oe(ram_n_oe), .ram_n_we(ram_n_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .dbg_state(dbg_state)
    );

    // Behavioural RAM: asynchronous read, write on the rising edge.
    logic [DW-1:0] mem [256];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (!ram_n_cs && !ram_n_we) mem[ram_addr] = ram_wdata;
    end

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    logic [DW-1:0] ref_mem [256];
    logic [EXP_W-1:0] gnt_q[$];
    logic [EXP_W-1:0] exp_q[$];
    int            gnt_times[$];
    txn_t          cpu_src[$], ldr_src[$];
    logic          last_owner = 1'b1;
    int            first_wait [2];
    bit            mon_on = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [EXP_W-1:0] pack_exp(input logic owner, input logic wr,
                                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {owner, wr, a, d};
    endfunction

    // Reference: the RAM contents follow the predicted grant order.
    function automatic void expect_txn(input logic owner, input txn_t t);
        gnt_q.push_back(pack_exp(owner, t.wr, t.addr, t.data));
        if (t.wr) begin
            ref_mem[t.addr] = t.data;
            exp_q.push_back(pack_exp(owner, 1'b1, t.addr, t.data));
        end else begin
            exp_q.push_back(pack_exp(owner, 1'b0, t.addr, ref_mem[t.addr]));
        end
    endfunction

    // ---------------- monitor ----------------
    logic [1:0]       prev_gnt = 2'b00;
    logic             prev_rst = 1'b1;
    logic [DW-1:0]    held_rdata = '0;
    logic [EXP_W-1:0] e;

    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_rst) held_rdata = '0;
            check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
            check("done_latency", done, prev_rst ? 2'b00 : prev_gnt);
            if (gnt != 2'b00) begin
                gnt_times.push_back(cyc);
                if (gnt_q.size() == 0) begin
                    check("unexpected_gnt", gnt, 2'b00);
                end else begin
                    e = gnt_q.pop_front();
                    check("gnt_owner", gnt, {e[EXP_W-1], ~e[EXP_W-1]});
                    check("access_strobes", {ram_n_cs, ram_n_oe, ram_n_we},
                          e[EXP_W-2] ? 3'b010 : 3'b001);
                    check("access_addr", ram_addr, e[AW+DW-1:DW]);
                    if (e[EXP_W-2]) check("access_wdata", ram_wdata, e[DW-1:0]);
                end
            end else begin
                check("idle_strobes", {ram_n_cs, ram_n_oe, ram_n_we}, 3'b111);
            end
            if (done != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", done, {e[EXP_W-1], ~e[EXP_W-1]});
                    if (!e[EXP_W-2]) begin
                        check("rdata", rdata, e[DW-1:0]);
                        held_rdata = e[DW-1:0];
                    end
                end
            end
            check("rdata_hold", rdata, held_rdata);
            prev_gnt = gnt;
            prev_rst = reset;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic idx);
        txn_t t;
        int   waited;
        while (1) begin
            if (!idx) begin
                if (cpu_src.size() == 0) break;
                t = cpu_src.pop_front();
                req0_r = 1'b1; we0_r = t.wr; addr0 = t.addr; wdata0 = t.data;
            end else begin
                if (ldr_src.size() == 0) break;
                t = ldr_src.pop_front();
                req1_r = 1'b1; we1_r = t.wr; addr1 = t.addr; wdata1 = t.data;
            end
            waited = 0;
            do begin
                @(posedge clk); #1;
                waited++;
            end while (gnt[idx] !== 1'b1 && waited < 300);
            if (first_wait[idx] == 0) first_wait[idx] = waited;
            check("gnt_seen", gnt[idx], 1'b1);
            if (gnt[idx] !== 1'b1) begin
                if (!idx) cpu_src.delete(); else ldr_src.delete();
                break;
            end
        end
        if (!idx) req0_r = 1'b0; else req1_r = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (exp_q.size() != 0 || gnt_q.size() != 0); k++) @(posedge clk);
        #1;
        check("drain_exp", exp_q.size(), 0);
        exp_q.delete();
        gnt_q.delete();
    endtask

    // Both requesters start together and re-request immediately after each
    // grant, so the grant order is fully determined by the tie policy.
    task automatic run_phase();
        txn_t c[$], l[$], t;
        logic pick_l;
        c = cpu_src;
        l = ldr_src;
        first_wait[0] = 0;
        first_wait[1] = 0;
        while (c.size() != 0 || l.size() != 0) begin
            if (c.size() != 0 && l.size() != 0) pick_l = RR ? (last_owner == 1'b0) : 1'b0;
            else pick_l = (c.size() == 0);
            t = pick_l ? l.pop_front() : c.pop_front();
            expect_txn(pick_l, t);
            last_owner = pick_l;
        end
        fork
            drive(1'b0);
            drive(1'b1);
        join
        drain();
    endtask

    function automatic txn_t mk(input logic wr, input int a, input int d);
        txn_t t;
        t.wr = wr; t.addr = AW'(a); t.data = DW'(d);
        return t;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", dbg_state, 2'd0);
        check("rst_gnt", gnt, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_rdata", rdata, 0);
        check("rst_strobes", {ram_n_cs, ram_n_oe, ram_n_we}, 3'b111);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        mon_on = 1'b1;
        reset = 1'b0;
        @(posedge clk); #1;

        // CPU write then read of the same location
        cpu_src.push_back(mk(1, 'h10, 'hA5));
        cpu_src.push_back(mk(0, 'h10, 0));
        run_phase();
        check("first_gnt_latency", first_wait[0], 1);

        // Two simultaneous-request ties
        cpu_src.push_back(mk(0, 'h20, 0));
        ldr_src.push_back(mk(1, 'h30, 'h3C));
        run_phase();
        cpu_src.push_back(mk(0, 'h30, 0));
        ldr_src.push_back(mk(1, 'h20, 'hC3));
        run_phase();

        // Back-to-back loader writes, then readback
        for (int i = 0; i < 4; i++) ldr_src.push_back(mk(1, i, 'h11 * (i + 1)));
        gnt_times.delete();
        run_phase();
        for (int i = 1; i < 4; i++) check("b2b_gap", gnt_times[i] - gnt_times[i-1], 2);
        for (int i = 0; i < 4; i++) cpu_src.push_back(mk(0, i, 0));
        run_phase();

        // Continuous CPU reads with loader pending
        for (int i = 0; i < 8; i++) cpu_src.push_back(mk(0, $urandom_range(0, 3), 0));
        for (int i = 0; i < 4; i++) ldr_src.push_back(mk(1, 8 + i, $urandom_range(0, 255)));
        run_phase();

        // Randomized mixed traffic
        for (int p = 0; p < 25; p++) begin
            int nc, nl;
            nc = $urandom_range(0, 4);
            nl = $urandom_range(0, 4);
            for (int i = 0; i < nc; i++)
                cpu_src.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255)));
            for (int i = 0; i < nl; i++)
                ldr_src.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255)));
            run_phase();
        end

        // Reset in the ACCESS cycle of a write: the write lands, no done
        begin
            int waited;
            gnt_q.push_back(pack_exp(1'b0, 1'b1, 8'h40, 8'h5A));
            ref_mem[8'h40] = 8'h5A;
            req0_r = 1'b1; we0_r = 1'b1; addr0 = 8'h40; wdata0 = 8'h5A;
            waited = 0;
            do begin
                @(posedge clk); #1;
                waited++;
            end while (gnt[0] !== 1'b1 && waited < 20);
            check("rst_write_gnt", gnt[0], 1'b1);
            reset = 1'b1;
            req0_r = 1'b0;
            @(posedge clk); #1;
            check("rst_mid_strobes", {ram_n_cs, ram_n_oe, ram_n_we}, 3'b111);
            check("rst_mid_done", done, 2'b00);
            check("rst_mid_gnt", gnt, 2'b00);
            check("rst_mid_rdata", rdata, 0);
            check("rst_mid_state", dbg_state, 2'd0);
            reset = 1'b0;
            last_owner = 1'b1;
            gnt_q.delete();
        end
        cpu_src.push_back(mk(0, 'h40, 0));
        run_phase();

        // Idle hygiene
        repeat (10) @(posedge clk);
        #1;
        check("idle_strobes_end", {ram_n_cs, ram_n_oe, ram_n_we}, 3'b111);
        check("idle_gnt_done", {gnt, done}, 4'b0000);
        check("idle_rdata", rdata, 8'h5A);

        check("gnt_q_empty", gnt_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion within 50000 cycles, required finish");
        $fatal(1);
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the single-port 256x8 data RAM. It shares the RAM between the CPU data port (requester 0) and a program/debug loader port (requester 1). It accepts one transaction at a time and drives the RAM's active-low chip-select, output-enable and write-enable from registers. It returns read data with a one-cycle done pulse. It sits between the datapath/loader and the RAM, and replaces the direct wiring of controller strobes to the RAM.

## Interface
Parameters:
- ADDR_W, default 8: RAM address width.
- DATA_W, default 8: RAM data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- req[1:0]  in  2  request per requester; index 0 = CPU, 1 = loader.
- we[1:0]  in  2  1 = write, 0 = read, per requester.
- addr0, addr1  in  ADDR_W  address per requester.
- wdata0, wdata1  in  DATA_W  write data per requester.
- gnt[1:0]  out  2  one-cycle acceptance pulse, one-hot or zero.
- done[1:0]  out  2  one-cycle completion pulse to the owner.
- rdata  out  DATA_W  read data; valid while done is high for a read.
- ram_n_cs, ram_n_oe, ram_n_we  out  1  RAM strobes, active-low.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, combinational from the RAM.

## Operation
- The FSM is three states: IDLE, ACCESS, COMPLETE.
- IDLE:
  - Any req high → ACCESS.
  - Latch the winner's addr, we and wdata, and record the owner.
- ACCESS:
  - gnt[owner]=1.
  - Read: n_cs=0, n_oe=0, n_we=1.
  - Write: n_cs=0, n_oe=1, n_we=0. The RAM writes on the rising edge ending ACCESS.
  - For reads, capture ram_rdata into rdata at the end of the cycle.
  - Always → COMPLETE.
- COMPLETE:
  - done[owner]=1.
  - All strobes are 1 (deasserted).
  - Any req high → ACCESS with a new arbitration. Otherwise → IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until the cycle gnt is seen.
  - In the cycle after gnt, deassert req or present the next transaction.
- Default arbitration is fixed priority: the CPU wins on simultaneous requests.
- A losing request stays pending, with no timeout.
- rdata holds its last value until the next read completes. For writes, rdata is unchanged.
- ram_addr and ram_wdata hold the latched values outside ACCESS. They are don't-care to the RAM, but they must not glitch.

## Timing
- Reset values:
  - State IDLE.
  - gnt=0, done=0, rdata=0.
  - ram_n_cs=1, ram_n_oe=1, ram_n_we=1.
  - ram_addr=0, ram_wdata=0.
  - Round-robin pointer favours the CPU.
- All outputs are registered. There is no combinational path from req to any output.
- Latency:
  - req sampled in cycle N (IDLE).
  - gnt and strobes in N+1.
  - done and rdata in N+2.
- Throughput: one access per 2 cycles under back-to-back requests (ACCESS, COMPLETE, ACCESS, ...).
- Simultaneous req[0] and req[1]: exactly one gnt.
- Reset during ACCESS:
  - The strobes already driven in that cycle still act at the edge, so a write still lands.
  - Outputs go to their reset values at that edge.
  - done is never pulsed for the aborted transaction.
- Reset during COMPLETE: done is forced to 0 from the next cycle.

## Configuration
- RAM_ARB_RR_EN defined: round-robin.
  - On simultaneous requests, the requester not granted last wins.
  - The pointer updates on every grant.
  - Reset pointer: CPU wins the first tie.
- RAM_ARB_RR_EN undefined: fixed priority, CPU always wins. The loader can starve under continuous CPU traffic.

## Structure
- Package ram_arb_pkg:
  - State enum (IDLE, ACCESS, COMPLETE).
  - Requester index constants REQ_CPU=0, REQ_LDR=1.
  - Default widths.
- Sub-module ram_arb_pick: pure priority picker. Inputs are req[1:0] and the pointer; output is a one-hot winner. Round-robin vs fixed priority is selected by the macro.
- The FSM, latches and strobe registers live in ram_arbiter.

## Test plan
- Single CPU write, then read:
  - Stimulus: req0 with we0=1, addr0=0x10, wdata0=0xA5. Then req0 with we0=0, addr0=0x10.
  - Response: gnt[0] in N+1 with n_we=0; later done[0] with rdata=0xA5. n_we=1 throughout the read.
- Simultaneous requests:
  - Stimulus: req=2'b11, CPU reads 0x20, loader writes 0x30.
  - Fixed priority: CPU granted first, loader 2 cycles later.
  - Round-robin (RAM_ARB_RR_EN), second tie: loader granted first.
- Back-to-back loader writes:
  - Stimulus: loader writes 0x00..0x03 with data 0x11..0x44 continuously.
  - Response: gnt[1] every 2 cycles. Readback returns 0x11, 0x22, 0x33, 0x44.
- Starvation check, fixed priority: continuous CPU reads plus a pending loader request → gnt[1] never asserts. With RAM_ARB_RR_EN, gnt alternates 0,1,0,1.
- Reset mid-write:
  - Stimulus: assert reset in the ACCESS cycle of a write of 0x5A to 0x40.
  - Response: no done. All strobes are 1 the next cycle. Read of 0x40 afterwards returns 0x5A.
- Idle hygiene: no req for 10 cycles → strobes stay 1, gnt=done=0, and rdata holds its last value.
